// File: rtl/rice_core_pkg.sv
// Shared types for the rice core front end: IF->ID result payload, PC and instruction words.
package rice_core_pkg;

   localparam int unsigned RICE_CORE_XLEN       = 32;
   localparam int unsigned RICE_CORE_INST_W     = 32;
   localparam int unsigned RICE_CORE_INST_BYTES = 4;

   typedef logic [RICE_CORE_XLEN-1:0]   rice_core_pc;
   typedef logic [RICE_CORE_INST_W-1:0] rice_core_inst;

   typedef struct packed {
      logic          valid;
      rice_core_pc   pc;
      rice_core_inst inst;
   } rice_core_if_result;

endpackage

// File: rtl/rice_core_pipeline_if.sv
// IF/ID handshake bundle: ID drives stall/flush/redirect, IF drives the fetched instruction.
interface rice_core_pipeline_if;
   import rice_core_pkg::*;

   logic               stall;
   logic               flush;
   rice_core_pc        flush_pc;
   rice_core_if_result if_result;

   modport if_stage (input stall, flush, flush_pc, output if_result);
   modport id_stage (output stall, flush, flush_pc, input if_result);

endinterface

// File: rtl/rice_core_fetch_fifo.sv
// Small power-of-two FIFO with synchronous clear; head shows the last popped entry while empty.
module rice_core_fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    clear,
   input  logic [WIDTH-1:0]        push_data,
   output logic [WIDTH-1:0]        head,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Clear rewinds the write side only, so the read side keeps pointing past the last popped word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= rd_ptr;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head = (count == '0) ? mem[rd_ptr - PTR_W'(1)] : mem[rd_ptr];

endmodule

// File: rtl/rice_core_fetch_unit.sv
// IF stage: credit-limited in-order fetch with PC/instruction buffers and stale-response discard.
// Optional perf counters (o_fetch_count, o_discard_count) when RICE_CORE_FETCH_PERF_COUNTER_EN is defined.
module rice_core_fetch_unit
   import rice_core_pkg::*;
#(
   parameter int unsigned     XLEN         = RICE_CORE_XLEN,
   parameter int unsigned     DEPTH        = 2,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   rice_core_pipeline_if.if_stage      pipeline_if,
   output logic                        o_inst_request_valid,
   input  logic                        i_inst_request_ready,
   output logic [XLEN-1:0]             o_inst_address,
   input  logic                        i_inst_response_valid,
   input  logic [RICE_CORE_INST_W-1:0] i_inst_response_data
`ifdef RICE_CORE_FETCH_PERF_COUNTER_EN
   ,
   output logic [31:0]                 o_fetch_count,
   output logic [31:0]                 o_discard_count
`endif
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned OCC_W = CNT_W + 1;

   logic [XLEN-1:0]             pc;
   logic [XLEN-1:0]             pc_head;
   logic [RICE_CORE_INST_W-1:0] inst_head;
   logic [CNT_W-1:0]            pc_count;
   logic [CNT_W-1:0]            inst_count;
   logic [CNT_W-1:0]            discard_count;
   logic [OCC_W-1:0]            occupancy;
   logic [OCC_W-1:0]            outstanding;
   logic                        credit;
   logic                        req_valid_c;
   logic                        accept;
   logic                        resp_drop;
   logic                        inst_push;
   logic                        pop;
   rice_core_if_result          if_result_c;

   // Outstanding = every request whose response has not yet come back, stale or live.
   always_comb begin
      occupancy   = OCC_W'(pc_count) + OCC_W'(discard_count);
      outstanding = OCC_W'(discard_count) + OCC_W'(pc_count) - OCC_W'(inst_count);
      credit      = occupancy < OCC_W'(DEPTH);
      req_valid_c = credit && !pipeline_if.flush && !i_rst;
      accept      = req_valid_c && i_inst_request_ready;
      resp_drop   = i_inst_response_valid && (pipeline_if.flush || discard_count != '0);
      inst_push   = i_inst_response_valid && !resp_drop;
      pop         = (inst_count != '0) && !pipeline_if.stall && !pipeline_if.flush;
   end

   always_comb begin
      if_result_c       = '0;
      if_result_c.valid = inst_count != '0;
      if_result_c.pc    = pc_head;
      if_result_c.inst  = inst_head;
   end

   assign pipeline_if.if_result = if_result_c;
   assign o_inst_request_valid  = req_valid_c;
   assign o_inst_address        = pc;

   // On redirect, all live in-flight requests become stale; a response landing now is already dropped.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc            <= RESET_VECTOR;
         discard_count <= '0;
      end else if (pipeline_if.flush) begin
         pc            <= {pipeline_if.flush_pc[XLEN-1:2], 2'b00};
         discard_count <= CNT_W'(outstanding - OCC_W'(i_inst_response_valid));
      end else begin
         if (accept) begin
            pc <= pc + XLEN'(RICE_CORE_INST_BYTES);
         end
         if (i_inst_response_valid && discard_count != '0) begin
            discard_count <= discard_count - CNT_W'(1);
         end
      end
   end

   rice_core_fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) pc_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .push      (accept),
      .pop       (pop),
      .clear     (pipeline_if.flush),
      .push_data (pc),
      .head      (pc_head),
      .count     (pc_count)
   );

   rice_core_fetch_fifo #(.WIDTH(RICE_CORE_INST_W), .DEPTH(DEPTH)) inst_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .push      (inst_push),
      .pop       (pop),
      .clear     (pipeline_if.flush),
      .push_data (i_inst_response_data),
      .head      (inst_head),
      .count     (inst_count)
   );

`ifdef RICE_CORE_FETCH_PERF_COUNTER_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_fetch_count   <= '0;
         o_discard_count <= '0;
      end else begin
         if (pop) begin
            o_fetch_count <= o_fetch_count + 32'd1;
         end
         if (resp_drop) begin
            o_discard_count <= o_discard_count + 32'd1;
         end
      end
   end
`endif

   no_orphan_response: assert property (@(posedge i_clk) disable iff (i_rst)
      i_inst_response_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_rice_core_fetch_unit.sv
// Directed + random bench for rice_core_fetch_unit against an epoch-tagged transaction model.
module tb_rice_core_fetch_unit;
   import rice_core_pkg::*;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] RV    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [31:0] fetch_cnt;
   logic [31:0] disc_cnt;

   rice_core_pipeline_if pif ();

   always #5 clk = ~clk;

   rice_core_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
      .i_clk                 (clk),
      .i_rst                 (rst),
      .pipeline_if           (pif),
      .o_inst_request_valid  (req_valid),
      .i_inst_request_ready  (req_ready),
      .o_inst_address        (addr),
      .i_inst_response_valid (resp_valid),
      .i_inst_response_data  (resp_data)
`ifdef RICE_CORE_FETCH_PERF_COUNTER_EN
      ,
      .o_fetch_count         (fetch_cnt),
      .o_discard_count       (disc_cnt)
`endif
   );

`ifndef RICE_CORE_FETCH_PERF_COUNTER_EN
   assign fetch_cnt = '0;
   assign disc_cnt  = '0;
`endif

   // Bus transaction tagged with the redirect epoch it was issued in; older epochs are stale.
   typedef struct {
      logic [31:0] a;
      int          epoch;
      int          due;
   } bus_t;

   bus_t        bus_q[$];
   logic [31:0] pcq[$];
   logic [31:0] instq[$];
   logic [31:0] mpc;
   logic [31:0] m_fetch;
   logic [31:0] m_disc;
   int          epoch;
   int          cyc;
   int          lat_max;
   int          errors;
   int          checks;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
   endfunction

   function automatic logic resp_due();
      return (bus_q.size() > 0) && (bus_q[0].due <= cyc);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_req_valid", 32'(req_valid), 32'd0);
      chk("rst_if_valid", 32'(pif.if_result.valid), 32'd0);
      chk("rst_address", addr, RV);
`ifdef RICE_CORE_FETCH_PERF_COUNTER_EN
      chk("rst_fetch_count", fetch_cnt, 32'd0);
      chk("rst_discard_count", disc_cnt, 32'd0);
`endif
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      #2;
      rst          = 1'b1;
      pif.stall    = 1'b0;
      pif.flush    = 1'b0;
      pif.flush_pc = '0;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_data    = '0;
      bus_q.delete();
      pcq.delete();
      instq.delete();
      mpc     = RV;
      epoch   = 0;
      m_fetch = '0;
      m_disc  = '0;
      #1;
      chk_reset_state();
      repeat (n) begin
         @(negedge clk);
         #1;
         chk_reset_state();
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock: drive inputs, check outputs against the model, then advance the model.
   task automatic cycle(input logic st, input logic fl, input logic [31:0] fpc, input int rdy_pct);
      logic        rdy;
      logic        rv;
      logic        exp_req;
      logic        do_pop;
      logic [31:0] rd;
      int          stale;
      int          d;
      bus_t        e;
      @(negedge clk);
      rdy = ($urandom_range(99) < rdy_pct);
      rv  = resp_due();
      rd  = rv ? mem_word(bus_q[0].a) : 32'h0;
      pif.stall    = st;
      pif.flush    = fl;
      pif.flush_pc = fpc;
      req_ready    = rdy;
      resp_valid   = rv;
      resp_data    = rv ? rd : $urandom();
      stale = 0;
      foreach (bus_q[i]) if (bus_q[i].epoch != epoch) stale++;
      exp_req = !fl && ((pcq.size() + stale) < DEPTH);
      #1;
      chk("req_valid", 32'(req_valid), 32'(exp_req));
      chk("address", addr, mpc);
      chk("if_valid", 32'(pif.if_result.valid), 32'(instq.size() > 0));
      if (instq.size() > 0) begin
         chk("if_pc", pif.if_result.pc, pcq[0]);
         chk("if_inst", pif.if_result.inst, instq[0]);
      end
`ifdef RICE_CORE_FETCH_PERF_COUNTER_EN
      chk("fetch_count", fetch_cnt, m_fetch);
      chk("discard_count", disc_cnt, m_disc);
`endif
      @(posedge clk);
      do_pop = (instq.size() > 0) && !st && !fl;
      if (rv) begin
         e = bus_q.pop_front();
         if (fl || e.epoch != epoch) m_disc++;
         else instq.push_back(rd);
      end
      if (do_pop) begin
         void'(pcq.pop_front());
         void'(instq.pop_front());
         m_fetch++;
      end
      if (fl) begin
         pcq.delete();
         instq.delete();
         epoch++;
         mpc = {fpc[31:2], 2'b00};
      end
      if (exp_req && rdy) begin
         d = cyc + 1 + int'($urandom_range(lat_max - 1));
         if (bus_q.size() > 0 && d <= bus_q[$].due) d = bus_q[$].due + 1;
         pcq.push_back(mpc);
         bus_q.push_back('{a: mpc, epoch: epoch, due: d});
         mpc = mpc + 32'd4;
      end
      cyc++;
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      cyc          = 0;
      lat_max      = 1;
      rst          = 1'b1;
      pif.stall    = 1'b0;
      pif.flush    = 1'b0;
      pif.flush_pc = '0;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_data    = '0;
      do_reset(3);

      // Streaming with single-cycle bus latency.
      repeat (12) cycle(1'b0, 1'b0, 32'h0, 100);

      // Long stall, then release.
      repeat (10) cycle(1'b1, 1'b0, 32'h0, 100);
      repeat (6) cycle(1'b0, 1'b0, 32'h0, 100);

      // Bus not ready: address must hold.
      repeat (5) cycle(1'b0, 1'b0, 32'h0, 0);
      repeat (4) cycle(1'b0, 1'b0, 32'h0, 100);

      // Redirect with requests in flight and a misaligned target.
      lat_max = 3;
      repeat (3) cycle(1'b1, 1'b0, 32'h0, 100);
      cycle(1'b0, 1'b1, 32'h0000_0103, 100);
      repeat (10) cycle(1'b0, 1'b0, 32'h0, 100);

      // Flush coinciding with stall and a response.
      for (int k = 0; k < 20 && !resp_due(); k++) cycle(1'b0, 1'b0, 32'h0, 100);
      chk("resp_due_before_flush", 32'(resp_due()), 32'd1);
      cycle(1'b1, 1'b1, 32'h0000_0200, 100);
      repeat (8) cycle(1'b0, 1'b0, 32'h0, 100);

      // Back-to-back redirects.
      cycle(1'b0, 1'b1, 32'h0000_0300, 100);
      cycle(1'b0, 1'b1, 32'h0000_0404, 100);
      cycle(1'b1, 1'b1, 32'h0000_0502, 100);
      repeat (8) cycle(1'b0, 1'b0, 32'h0, 100);

      // PC wrap past the top of the address space.
      cycle(1'b0, 1'b1, 32'hFFFF_FFF4, 100);
      repeat (12) cycle(1'b0, 1'b0, 32'h0, 100);

      // Randomized traffic.
      lat_max = 4;
      repeat (600) cycle($urandom_range(99) < 30, $urandom_range(99) < 4, $urandom(), 75);

      // Reset in the middle of a burst.
      repeat (4) cycle(1'b0, 1'b0, 32'h0, 100);
      do_reset(2);
      lat_max = 2;
      repeat (10) cycle(1'b0, 1'b0, 32'h0, 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
